// File: rtl/segment_transition_ctl.sv
// ---------------------------------------------------------------------------
// segment_transition_ctl
//
// Segment sequencer shared by the modulation and STM sample readers. Tracks
// the active segment, its sample index and the number of completed loops,
// and switches to a requested segment using one of five transition modes:
//   8'h00 SYNC_IDX  : switch on the TICK at which the current segment wraps
//   8'h01 SYS_TIME  : switch on the first TICK with sys_time >= req_value
//   8'h02 GPIO      : switch on the first TICK with gpio_in[req_value[1:0]]
//   8'hF0 EXT       : switch at once, then auto-rotate through all segments
//   8'hFF IMMEDIATE : switch at once
//
// Ports
//   clk, rst         system clock, asynchronous active-high reset
//   update_settings  one-cycle pulse that latches the req_* fields
//   req_segment      target segment
//   req_mode         transition mode (encoding above)
//   req_value        SYS_TIME target time, or GPIO input number in [1:0]
//   req_rep          loop count minus one for the target; all-ones = forever
//   cycle            per-segment last sample index, segment 0 in the LSBs
//   tick             sample-advance strobe
//   sys_time         current system time
//   gpio_in          external trigger inputs
//   segment, idx     active segment and sample index
//   stopped          loops exhausted, idx frozen on the last sample
//   pending          a timed transition is latched but not yet applied
//   err              last request was rejected; cleared by the next good one
// ---------------------------------------------------------------------------
module segment_transition_ctl #(
    parameter int NUM_SEGMENT = 4,
    parameter int IDX_WIDTH   = 16,
    parameter int REP_WIDTH   = 16,
    parameter int TIME_WIDTH  = 64,
    parameter int GPIO_WIDTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             update_settings,
    input  logic [$clog2(NUM_SEGMENT)-1:0]   req_segment,
    input  logic [7:0]                       req_mode,
    input  logic [TIME_WIDTH-1:0]            req_value,
    input  logic [REP_WIDTH-1:0]             req_rep,
    input  logic [NUM_SEGMENT*IDX_WIDTH-1:0] cycle,
    input  logic                             tick,
    input  logic [TIME_WIDTH-1:0]            sys_time,
    input  logic [GPIO_WIDTH-1:0]            gpio_in,
    output logic [$clog2(NUM_SEGMENT)-1:0]   segment,
    output logic [IDX_WIDTH-1:0]             idx,
    output logic                             stopped,
    output logic                             pending,
    output logic                             err
);

    // state          | meaning
    // ST_RUN         | playing the active segment, nothing pending
    // ST_STOPPED     | loops exhausted, idx frozen, nothing pending
    // ST_WAIT_RUN    | playing the active segment, transition pending
    // ST_WAIT_STOPPED| frozen on the last sample, transition pending

    localparam int SEG_W = $clog2(NUM_SEGMENT);

    localparam logic [7:0] MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0] MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0] MODE_GPIO      = 8'h02;
    localparam logic [7:0] MODE_EXT       = 8'hF0;
    localparam logic [7:0] MODE_IMMEDIATE = 8'hFF;

    localparam logic [SEG_W:0]   SEG_COUNT = (SEG_W+1)'(NUM_SEGMENT);
    localparam logic [SEG_W-1:0] SEG_LAST  = SEG_W'(NUM_SEGMENT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STOPPED,
        ST_WAIT_RUN,
        ST_WAIT_STOPPED
    } state_t;

    state_t                state;
    logic [REP_WIDTH-1:0]  rep;
    logic [REP_WIDTH-1:0]  loop_cnt;
    logic [7:0]            active_mode;

    logic [SEG_W-1:0]      pend_segment;
    logic [7:0]            pend_mode;
    logic [TIME_WIDTH-1:0] pend_value;
    logic [REP_WIDTH-1:0]  pend_rep;

    logic [IDX_WIDTH-1:0]  cycle_arr [NUM_SEGMENT];
    logic [IDX_WIDTH-1:0]  cycle_cur;
    logic [3:0]            gpio_ext;
    logic                  holding;
    logic                  waiting;
    logic                  at_wrap;
    logic                  done;
    logic                  req_mode_ok;
    logic                  req_valid;
    logic                  req_direct;
    logic                  hit;
    logic [REP_WIDTH-1:0]  loop_next;

    // Result of one TICK on the active segment, ignoring any pending request.
    logic [SEG_W-1:0]      play_seg;
    logic [IDX_WIDTH-1:0]  play_idx;
    logic [REP_WIDTH-1:0]  play_loop;
    logic                  play_stop;

    always_comb begin
        for (int s = 0; s < NUM_SEGMENT; s++) begin
            cycle_arr[s] = cycle[s*IDX_WIDTH +: IDX_WIDTH];
        end
        cycle_cur = cycle_arr[segment];

        gpio_ext = '0;
        for (int g = 0; g < GPIO_WIDTH && g < 4; g++) begin
            gpio_ext[g] = gpio_in[g];
        end
    end

    always_comb begin
        holding   = (state == ST_STOPPED) || (state == ST_WAIT_STOPPED);
        waiting   = (state == ST_WAIT_RUN) || (state == ST_WAIT_STOPPED);
        // cycle is live: an index already past a shrunk cycle wraps too
        at_wrap   = (idx >= cycle_cur);
        loop_next = loop_cnt + REP_WIDTH'(1);
        // rep+1 cannot overflow because all-ones (infinite) is excluded
        done      = at_wrap && (rep != '1) && (loop_next == rep + REP_WIDTH'(1));

        req_mode_ok = (req_mode == MODE_SYNC_IDX) || (req_mode == MODE_SYS_TIME) ||
                      (req_mode == MODE_GPIO) || (req_mode == MODE_EXT) ||
                      (req_mode == MODE_IMMEDIATE);
        req_valid   = req_mode_ok && ({1'b0, req_segment} < SEG_COUNT);
        req_direct  = (req_mode == MODE_EXT) || (req_mode == MODE_IMMEDIATE);

        case (pend_mode)
            MODE_SYNC_IDX: hit = holding || at_wrap;
            MODE_SYS_TIME: hit = (sys_time >= pend_value);
            MODE_GPIO:     hit = gpio_ext[pend_value[1:0]];
            default:       hit = 1'b0;
        endcase
    end

    always_comb begin
        play_seg  = segment;
        play_idx  = idx;
        play_loop = loop_cnt;
        play_stop = 1'b0;
        if (!at_wrap) begin
            play_idx = idx + IDX_WIDTH'(1);
        end else if (done && active_mode == MODE_EXT) begin
            play_seg  = (segment == SEG_LAST) ? '0 : segment + SEG_W'(1);
            play_idx  = '0;
            play_loop = '0;
        end else if (done) begin
            play_idx  = cycle_cur;
            play_loop = loop_next;
            play_stop = 1'b1;
        end else begin
            play_idx  = '0;
            play_loop = loop_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            segment      <= '0;
            idx          <= '0;
            loop_cnt     <= '0;
            rep          <= '1;
            active_mode  <= MODE_SYNC_IDX;
            pend_segment <= '0;
            pend_mode    <= MODE_SYNC_IDX;
            pend_value   <= '0;
            pend_rep     <= '0;
            stopped      <= 1'b0;
            pending      <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (update_settings) begin
                err <= !req_valid;
            end

            if (update_settings && req_valid && req_direct) begin
                segment     <= req_segment;
                idx         <= '0;
                loop_cnt    <= '0;
                rep         <= req_rep;
                active_mode <= req_mode;
                state       <= ST_RUN;
                stopped     <= 1'b0;
                pending     <= 1'b0;
            end else if (update_settings && req_valid) begin
                // A new request replaces any pending one, even on a TICK
                // that would have applied it; the TICK still plays normally.
                pend_segment <= req_segment;
                pend_mode    <= req_mode;
                pend_value   <= req_value;
                pend_rep     <= req_rep;
                pending      <= 1'b1;
                if (tick && !holding) begin
                    segment  <= play_seg;
                    idx      <= play_idx;
                    loop_cnt <= play_loop;
                end
                if (holding || (tick && play_stop)) begin
                    state   <= ST_WAIT_STOPPED;
                    stopped <= 1'b1;
                end else begin
                    state   <= ST_WAIT_RUN;
                end
            end else if (waiting && tick && hit) begin
                // The qualifying TICK does not advance the old segment.
                segment     <= pend_segment;
                idx         <= '0;
                loop_cnt    <= '0;
                rep         <= pend_rep;
                active_mode <= pend_mode;
                state       <= ST_RUN;
                stopped     <= 1'b0;
                pending     <= 1'b0;
            end else if (tick && !holding) begin
                segment  <= play_seg;
                idx      <= play_idx;
                loop_cnt <= play_loop;
                if (play_stop) begin
                    stopped <= 1'b1;
                    state   <= waiting ? ST_WAIT_STOPPED : ST_STOPPED;
                end
            end
        end
    end

endmodule
